// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle FETCH/EXEC sequencer for the 8-bit CPU datapath.
// Registers Z/C so that branches test the last ALU result. Also provides a
// programmable WAIT stall, illegal-opcode trapping and a latched HALT.
// Optional feature macro: CTRL_STALL_EN adds mem_ready, which holds FETCH
// until instruction memory is ready.
module ctrl_fsm #(
    parameter int OPW     = 4,
    parameter int ALUSELW = 4,
    parameter int WAITW   = 4
) (
    input  logic               CLK,
    input  logic               CLB,
    input  logic               run,
    input  logic [OPW-1:0]     opcode,
    input  logic [WAITW-1:0]   imm,
    input  logic               Z,
    input  logic               C,
`ifdef CTRL_STALL_EN
    input  logic               mem_ready,
`endif
    output logic               LoadIR,
    output logic               IncPC,
    output logic               SelPC,
    output logic               LoadPC,
    output logic               LoadReg,
    output logic               LoadAcc,
    output logic [1:0]         SelAcc,
    output logic [ALUSELW-1:0] SelALU,
    output logic               LoadFlags,
    output logic [1:0]         state,
    output logic               halted,
    output logic               illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_zf;
    logic             r_cf;
    logic             r_illegal;
    logic [WAITW-1:0] r_cnt;
    logic             w_ready;
    logic             w_upper;
    logic             w_illegal;
    logic [3:0]       w_op;

`ifdef CTRL_STALL_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    // Any set opcode bit above bit 3 makes the instruction illegal.
    if (OPW > 4) begin : g_upper
        assign w_upper = |opcode[OPW-1:4];
    end else begin : g_no_upper
        assign w_upper = 1'b0;
    end

    assign w_op      = opcode[3:0];
    assign w_illegal = w_upper | (w_op == 4'h9) | (w_op == 4'hE);

    assign state   = r_state;
    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;

    // Next-state and strobe decode; every strobe defaults to 0.
    always_comb begin
        w_next    = r_state;
        LoadIR    = 1'b0;
        IncPC     = 1'b0;
        SelPC     = 1'b0;
        LoadPC    = 1'b0;
        LoadReg   = 1'b0;
        LoadAcc   = 1'b0;
        SelAcc    = 2'b00;
        SelALU    = '0;
        LoadFlags = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_ready) begin
                    LoadIR = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_FETCH;
                if (w_illegal) begin
                    w_next = S_HALT;
                end else begin
                    case (w_op)
                        4'h0: begin
                            if (r_cnt == '0) IncPC = 1'b1;
                            else             w_next = S_EXEC;
                        end
                        4'h1: begin LoadAcc = 1'b1; IncPC = 1'b1; SelALU = ALUSELW'(4'b1000); LoadFlags = 1'b1; end
                        4'h2: begin LoadAcc = 1'b1; IncPC = 1'b1; SelALU = ALUSELW'(4'b1100); LoadFlags = 1'b1; end
                        4'h3: begin LoadAcc = 1'b1; IncPC = 1'b1; SelALU = ALUSELW'(4'b0100); LoadFlags = 1'b1; end
                        4'h4: begin LoadAcc = 1'b1; IncPC = 1'b1; SelAcc = 2'b10; end
                        4'h5: begin LoadReg = 1'b1; IncPC = 1'b1; end
                        4'h6: begin SelPC = 1'b1; LoadPC = r_zf; IncPC = ~r_zf; end
                        4'h7: begin LoadPC = r_zf; IncPC = ~r_zf; end
                        4'h8: begin SelPC = 1'b1; LoadPC = r_cf; IncPC = ~r_cf; end
                        4'hA: begin LoadPC = r_cf; IncPC = ~r_cf; end
                        4'hB: begin LoadAcc = 1'b1; IncPC = 1'b1; SelALU = ALUSELW'(4'b0011); LoadFlags = 1'b1; end
                        4'hC: begin LoadAcc = 1'b1; IncPC = 1'b1; SelALU = ALUSELW'(4'b0001); LoadFlags = 1'b1; end
                        4'hD: begin LoadAcc = 1'b1; IncPC = 1'b1; SelAcc = 2'b11; end
                        default: w_next = S_HALT; // STOP (0x9/0xE caught above)
                    endcase
                end
            end
            default: ; // HALT: only CLB leaves
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (CLB) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // WAIT counter: load imm on EXEC entry, count down to 0 while in EXEC.
    always_ff @(posedge CLK) begin
        if (CLB)
            r_cnt <= '0;
        else if (r_state == S_FETCH && w_next == S_EXEC)
            r_cnt <= imm;
        else if (r_state == S_EXEC && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // Flag capture on ALU ops, and the sticky illegal-opcode trap.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            r_zf      <= 1'b0;
            r_cf      <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == S_EXEC) begin
            if (LoadFlags) begin
                r_zf <= Z;
                r_cf <= C;
            end
            if (w_illegal) r_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Testbench for ctrl_fsm. It uses an instruction-level reference model: a
// per-opcode decode table, WAIT length imm+1, and flags that are updated
// only after an ALU instruction retires.
module tb_ctrl_fsm;
    localparam int OPW = 4, ALUSELW = 4, WAITW = 4;

    logic CLK = 1'b0;
    logic CLB, run, Z, C, mem_ready;
    logic [OPW-1:0]     opcode;
    logic [WAITW-1:0]   imm;
    logic LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, LoadFlags, halted, illegal;
    logic [1:0]         SelAcc, state;
    logic [ALUSELW-1:0] SelALU;

    ctrl_fsm #(.OPW(OPW), .ALUSELW(ALUSELW), .WAITW(WAITW)) dut (
        .CLK(CLK), .CLB(CLB), .run(run), .opcode(opcode), .imm(imm), .Z(Z), .C(C),
`ifdef CTRL_STALL_EN
        .mem_ready(mem_ready),
`endif
        .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg),
        .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .LoadFlags(LoadFlags),
        .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit m_zf, m_cf, m_ill;

    typedef struct packed {
        bit       ok;
        bit       stop;
        bit       la;
        bit       ip;
        bit       sp;
        bit       lr;
        bit       lf;
        bit [1:0] sa;
        bit [3:0] alu;
        bit [1:0] br;   // 0 none, 1 branch on zf, 2 branch on cf
    } row_t;
    row_t tbl [16];

    logic [16:0] obs;
    assign obs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
                  LoadFlags, state, halted, illegal};

    function automatic row_t mk(input bit ok, input bit stop, input bit la, input bit ip,
                                input bit sp, input bit lr, input bit lf, input bit [1:0] sa,
                                input bit [3:0] alu, input bit [1:0] br);
        row_t r;
        r = {ok, stop, la, ip, sp, lr, lf, sa, alu, br};
        return r;
    endfunction

    function automatic logic [16:0] ev(input int st, input bit ir, input bit ip, input bit sp,
                                       input bit lp, input bit lr, input bit la,
                                       input bit [1:0] sa, input bit [3:0] alu, input bit lf);
        logic [1:0] s;
        s = st[1:0];
        return {ir, ip, sp, lp, lr, la, sa, alu, lf, s, (st == 3), m_ill};
    endfunction

    function automatic logic [16:0] ev_st(input int st);
        return ev(st, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp);
        #1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #2;
    endtask

    task automatic start();
        run = 1'b1;
        chk("idle_run", ev_st(0));
        nxt();
        run = 1'b0;
    endtask

    task automatic do_reset();
        CLB = 1'b1;
        nxt();
        CLB = 1'b0;
        m_zf = 0; m_cf = 0; m_ill = 0;
        chk("after_reset", ev_st(0));
    endtask

    // One full instruction, starting from FETCH.
    task automatic do_instr(input bit [3:0] op, input bit [3:0] iv, input bit z, input bit c);
        row_t r;
        int   n;
        bit   ip, lp, f;
        r = tbl[op];
        opcode = OPW'(op); imm = iv; Z = z; C = c; mem_ready = 1'b1;
        chk("fetch", ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0));
        nxt();
        n = (op == 4'h0) ? int'(iv) + 1 : 1;
        for (int k = 0; k < n; k++) begin
            if (!r.ok || r.stop) begin
                chk($sformatf("exec_nop_op%0h", op), ev_st(2));
            end else begin
                ip = (op == 4'h0) ? (k == n - 1) : r.ip;
                lp = 0;
                if (r.br != 0) begin
                    f  = (r.br == 1) ? m_zf : m_cf;
                    lp = f;
                    ip = !f;
                end
                chk($sformatf("exec_op%0h_k%0d", op, k),
                    ev(2, 0, ip, r.sp, lp, r.lr, r.la, r.sa, r.alu, r.lf));
            end
            nxt();
        end
        if (r.lf) begin m_zf = z; m_cf = c; end
        if (!r.ok) m_ill = 1;
    endtask

    task automatic halt_hold(input int n);
        run = 1'b1;
        for (int i = 0; i < n; i++) begin
            opcode = OPW'($urandom_range(0, 15));
            Z = 1'($urandom); C = 1'($urandom);
            chk("halt_hold", ev_st(3));
            nxt();
        end
        run = 1'b0;
    endtask

    bit [3:0] legal [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                             4'h8, 4'hA, 4'hB, 4'hC, 4'hD};

    initial begin
        //                 ok st la ip sp lr lf  sa     alu      br
        tbl[4'h0] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'd0);
        tbl[4'h1] = mk(1, 0, 1, 1, 0, 0, 1, 2'b00, 4'b1000, 2'd0);
        tbl[4'h2] = mk(1, 0, 1, 1, 0, 0, 1, 2'b00, 4'b1100, 2'd0);
        tbl[4'h3] = mk(1, 0, 1, 1, 0, 0, 1, 2'b00, 4'b0100, 2'd0);
        tbl[4'h4] = mk(1, 0, 1, 1, 0, 0, 0, 2'b10, 4'b0000, 2'd0);
        tbl[4'h5] = mk(1, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0000, 2'd0);
        tbl[4'h6] = mk(1, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 2'd1);
        tbl[4'h7] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'd1);
        tbl[4'h8] = mk(1, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 2'd2);
        tbl[4'h9] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'd0);
        tbl[4'hA] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'd2);
        tbl[4'hB] = mk(1, 0, 1, 1, 0, 0, 1, 2'b00, 4'b0011, 2'd0);
        tbl[4'hC] = mk(1, 0, 1, 1, 0, 0, 1, 2'b00, 4'b0001, 2'd0);
        tbl[4'hD] = mk(1, 0, 1, 1, 0, 0, 0, 2'b11, 4'b0000, 2'd0);
        tbl[4'hE] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'd0);
        tbl[4'hF] = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'd0);

        m_zf = 0; m_cf = 0; m_ill = 0;
        CLB = 1'b1; run = 1'b0; opcode = '0; imm = '0; Z = 1'b0; C = 1'b0; mem_ready = 1'b0;
        nxt();
        nxt();
        chk("reset_state", ev_st(0));
        CLB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("idle", ev_st(0));
            nxt();
        end

        // Branches see the flags latched by the previous ALU op, not the live Z/C.
        start();
        do_instr(4'h1, 0, 1, 0);
        do_instr(4'h7, 0, 0, 1);
        do_instr(4'h1, 0, 0, 1);
        do_instr(4'h7, 0, 1, 0);
        // Flags survive non-ALU instructions.
        do_instr(4'h1, 0, 0, 1);
        do_instr(4'h5, 0, 0, 0);
        do_instr(4'h8, 0, 0, 0);
        // WAIT lengths.
        do_instr(4'h0, 3, 0, 0);
        do_instr(4'h0, 0, 0, 0);
`ifdef CTRL_STALL_EN
        mem_ready = 1'b0;
        opcode = OPW'(4'h1);
        for (int i = 0; i < 3; i++) begin
            chk("stall", ev_st(1));
            nxt();
        end
        do_instr(4'h1, 0, 1, 1);
`endif
        // STOP, then HALT ignores run.
        do_instr(4'hF, 0, 0, 0);
        halt_hold(10);
        do_reset();

        // Illegal trap is sticky until reset.
        start();
        do_instr(4'h9, 0, 0, 0);
        halt_hold(2);
        do_reset();

        // Reset in the middle of a WAIT also clears the flags.
        start();
        do_instr(4'h2, 0, 1, 1);
        opcode = OPW'(4'h0); imm = 4'd7; mem_ready = 1'b1;
        chk("wait_fetch", ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0));
        nxt();
        for (int i = 0; i < 2; i++) begin
            chk("wait_mid", ev_st(2));
            nxt();
        end
        do_reset();
        start();
        do_instr(4'h7, 0, 1, 1);
        do_instr(4'hA, 0, 1, 1);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            do_instr(legal[$urandom_range(0, 12)], 4'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
        end
        do_instr(4'hE, 0, 0, 0);
        halt_hold(3);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Parametrised multi-cycle successor to the single-cycle opcode decoder of the 8-bit CPU. Sequences each instruction through FETCH and EXEC states and registers the Z/C flags so that branches test the result of the last ALU operation. It adds a programmable WAIT stall, illegal-opcode trapping and a latched HALT. It drives the IR, program counter, register file, accumulator and ALU select lines of the existing datapath.

## Interface
Parameters:
- OPW, 4: opcode width, ≥4. Opcode bits above bit 3 must be zero, otherwise the opcode is illegal.
- ALUSELW, 4: SelALU width, ≥4. The 4-bit encodings below are zero-extended.
- WAITW, 4: WAIT counter width and imm width.

Ports:
- CLK  in  1  clock. One clock domain; all state updates on the rising edge.
- CLB  in  1  reset, synchronous, active-high.
- run  in  1  start; sampled in IDLE.
- opcode  in  OPW  IR opcode field; must be stable from the end of FETCH through EXEC.
- imm  in  WAITW  low immediate bits; gives the WAIT cycle count.
- Z  in  1  ALU zero output.
- C  in  1  ALU carry output.
- mem_ready  in  1  instruction memory ready. Present only with CTRL_STALL_EN.
- LoadIR  out  1  IR load strobe.
- IncPC  out  1  PC increment.
- SelPC  out  1  PC load source: 1 = register, 0 = immediate.
- LoadPC  out  1  PC load.
- LoadReg  out  1  register-file write.
- LoadAcc  out  1  accumulator load.
- SelAcc  out  2  accumulator source mux.
- SelALU  out  ALUSELW  ALU function.
- LoadFlags  out  1  flag-register capture strobe (reported for observability).
- state  out  2  IDLE=0, FETCH=1, EXEC=2, HALT=3.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an illegal opcode is executed.

## Operation
- All strobe outputs are combinational from the registered state, opcode and flags.
- In IDLE, in HALT, and whenever no row below applies, every strobe, SelAcc and SelALU is 0.
- FETCH:
  - Drives LoadIR=1.
  - Moves to EXEC on the next edge.
- EXEC decode, by opcode[3:0]. Fields not listed are 0.
  - 0x0 WAIT: IncPC=1 on the final cycle only. Stays in EXEC for imm extra cycles.
  - 0x1 ADD: LoadAcc=1, IncPC=1, SelALU=1000, LoadFlags=1.
  - 0x2 SUB: LoadAcc=1, IncPC=1, SelALU=1100, LoadFlags=1.
  - 0x3 NOR: LoadAcc=1, IncPC=1, SelALU=0100, LoadFlags=1.
  - 0x4 ACC←REG: LoadAcc=1, IncPC=1, SelAcc=10.
  - 0x5 REG←ACC: LoadReg=1, IncPC=1.
  - 0x6 JZ reg: SelPC=1, LoadPC=zf, IncPC=~zf.
  - 0x7 JZ imm: LoadPC=zf, IncPC=~zf.
  - 0x8 JC reg: SelPC=1, LoadPC=cf, IncPC=~cf.
  - 0xA JC imm: LoadPC=cf, IncPC=~cf.
  - 0xB SHL: LoadAcc=1, IncPC=1, SelALU=0011, LoadFlags=1.
  - 0xC SHR: LoadAcc=1, IncPC=1, SelALU=0001, LoadFlags=1.
  - 0xD ACC←IMM: LoadAcc=1, IncPC=1, SelAcc=11.
  - 0xF STOP: no strobes; next state HALT.
  - 0x9, 0xE, or any nonzero upper bit: illegal. No strobes; sets illegal; next state HALT.
- Flags:
  - zf and cf capture Z and C at the edge ending any EXEC cycle with LoadFlags=1.
  - They are otherwise held.
- State transitions:
  - IDLE→FETCH when run=1.
  - EXEC→FETCH after the instruction completes, except STOP and illegal opcodes, which go to HALT.
  - HALT is left only by CLB; run is ignored in HALT.
- WAIT counter:
  - Loaded with imm on entry to EXEC.
  - Decrements each EXEC cycle while nonzero.
  - The instruction completes on the cycle the counter reads 0.
  - imm=0 behaves as a single-cycle NOP.

## Timing
- Reset values (CLB=1 at an edge): state=IDLE, zf=cf=0, counter=0, illegal=0. All outputs 0.
- CLB takes priority over every other input, including in mid-EXEC and mid-WAIT.
- Instruction latency:
  - 2 cycles (FETCH + EXEC) for every non-WAIT opcode.
  - 2+imm cycles for WAIT.
- A branch sees the flags from the previous flag-setting instruction, never the same-cycle Z/C.
- A flag write and a branch test cannot coincide, because they are separate instructions.
- The counter wraps only by load; it never underflows below 0.

## Configuration
- CTRL_STALL_EN defined:
  - The mem_ready port exists.
  - FETCH holds, with LoadIR=0 and all strobes 0, until mem_ready=1.
  - LoadIR is asserted only in the FETCH cycle that sees mem_ready=1, then the FSM moves to EXEC.
- CTRL_STALL_EN undefined: no mem_ready port; FETCH always lasts exactly 1 cycle.

## Test plan
- Reset then idle: CLB=1 for 2 cycles, run=0 → state=0 and all outputs 0 for 5 cycles. run=1 → state=1 on the next cycle with LoadIR=1.
- Flag-gated branch: ADD with Z=1, then opcode 0x7 → the JZ EXEC cycle shows LoadPC=1, IncPC=0. Repeat with Z=0 at the ADD → LoadPC=0, IncPC=1.
- Flags held across non-ALU ops: ADD with C=1, then opcode 0x5, then 0x8 → LoadPC=1, SelPC=1 in the JC EXEC cycle.
- WAIT: opcode 0, imm=3 → 4 EXEC cycles, with IncPC=1 only in the last. imm=0 → 1 EXEC cycle.
- Halt and illegal:
  - opcode 0xF → state=3, halted=1, run ignored for 10 cycles.
  - After reset, opcode 0x9 → illegal=1 and state=3.
  - CLB clears both.
- CTRL_STALL_EN: mem_ready=0 for 3 cycles in FETCH → LoadIR=0, state=1. mem_ready=1 → LoadIR=1 for one cycle, then EXEC.
